weight_tile_scheduler: RTL
==========================

Name: weight_tile_scheduler

Overview:
Sequences one GEMM layer through `kernel_loader` and the activation (IA) tile path.
- Grants each weight-tile load and fires the send trigger once the tile is buffered.
- Then issues one start pulse per IA tile so the weight tile is reused across all of them, and advances until every weight tile is consumed.
- Sits between the layer-level CSR block and `kernel_loader`/IA loader; it is the sole source of `load_weight_granted` and `send_weight_trigger`.

Parameters:
- SIZE, 16, systolic array dimension; power of two, ≥2.
- REG_WIDTH, 32, width of dimension registers and counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle layer start; samples k/n/m
- k  in  REG_WIDTH  reduction dimension (weight rows)
- n  in  REG_WIDTH  weight columns
- m  in  REG_WIDTH  LHS rows (number of IA rows)
- init_cfg  out  1  pulse to `kernel_loader`/IA loader config latch
- load_weight_req  in  1  from `kernel_loader`
- load_weight_granted  out  1  single-cycle grant pulse
- weight_data_valid  in  1  weight tile buffered
- send_weight_trigger  out  1  single-cycle send pulse
- weight_sending_done  in  1  weight tile shifted into array
- ia_tile_start  out  1  single-cycle start for one IA tile
- ia_tile_done  in  1  IA tile computed and drained
- wt_tile_idx  out  REG_WIDTH  current weight tile index
- ia_tile_idx  out  REG_WIDTH  current IA tile index
- busy  out  1  high from the cycle after start until DONE exits
- layer_done  out  1  single-cycle completion pulse
- err  out  1  sticky protocol/timeout error; cleared by start

Behaviour:
- Reset (synchronous, `rst_n`=0 at posedge): state IDLE; all outputs and indices 0; err 0.
- Tile counts, computed in CFG as ceil(x/SIZE) = (x+SIZE-1)>>log2(SIZE), REG_WIDTH+1 internal width:
  - nkt = ceil(k/SIZE), nnt = ceil(n/SIZE), nmt = ceil(m/SIZE).
  - W = nkt*nnt weight tiles, truncated to REG_WIDTH.
- States:
  - IDLE: on start, latch k/n/m → CFG. `start` in any other state is ignored.
  - CFG: assert init_cfg for 1 cycle; compute counts.
    - If any dimension is 0 → DONE.
    - Else → GRANT.
  - GRANT: wait for load_weight_req=1; pulse load_weight_granted for exactly 1 cycle → WAITD.
  - WAITD: wait for weight_data_valid=1; pulse send_weight_trigger for 1 cycle → SEND.
  - SEND: wait for weight_sending_done → COMP; ia_tile_idx=0.
  - COMP: pulse ia_tile_start, wait for ia_tile_done.
    - If ia_tile_idx==nmt-1 → NEXT.
    - Else ia_tile_idx++ and re-pulse ia_tile_start on the next cycle.
  - NEXT:
    - If wt_tile_idx==W-1 → DONE.
    - Else wt_tile_idx++, ia_tile_idx=0 → GRANT.
  - DONE: layer_done 1 cycle; busy falls the same cycle → IDLE.
- Latency: load_weight_req seen in GRANT → grant in the next cycle. Each done/valid input → next pulse one cycle later.
- Protocol errors set err and continue:
  - ia_tile_done outside COMP.
  - weight_sending_done outside SEND.
  - weight_data_valid already high on WAITD entry is legal (immediate trigger).
- Simultaneous events: ia_tile_done in the same cycle as ia_tile_start is accepted.
- Mid-operation reset: everything returns to reset values; no pulse is emitted in that cycle.

Optional Feature:
- Macro: WEIGHT_SCHED_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts cycles in WAITD, SEND and COMP; it reloads on every state entry or handshake.
  - On reaching 0xFFFF: err=1 and state → DONE (layer_done still pulses).
- When undefined: no watchdog; those states wait indefinitely.

Decomposition:
- Package `weight_sched_pkg`:
  - state_t enum (IDLE, CFG, GRANT, WAITD, SEND, COMP, NEXT, DONE).
  - ceil_tiles function.
  - LOG2_SIZE constant.
  - TIMEOUT_MAX constant.
- Sub-module `sched_tile_counter`: index register with load-zero, increment and last-flag compare; instantiated twice, for wt and ia.

Test Plan:
- k=16, n=16, m=16, SIZE=16, `kernel_loader` model with 3-cycle data latency → 1 grant, 1 send, 1 ia_tile_start, layer_done; busy spans all.
- k=32, n=20, m=40 → W=4, nmt=3; 4 grants and 12 ia_tile_start pulses; ia_tile_idx cycles 0,1,2 per weight tile.
- m=0 → init_cfg, then layer_done 2 cycles after start; no grant/send/ia pulses; err=0.
- load_weight_req held low 50 cycles in GRANT → no grant issued; grant 1 cycle after req rises.
- Spurious ia_tile_done during WAITD → err=1, sequence still completes; next start clears err.
- With WEIGHT_SCHED_TIMEOUT_EN, weight_data_valid never asserted → err=1 and layer_done 65535 cycles after WAITD entry. Without the macro → stalls indefinitely, busy stays 1.

Source files
------------

// File: rtl/weight_sched_pkg.sv
// ============================================================================
// weight_sched_pkg: shared FSM encoding, constants and tile-count helper
// Rev 1.0
// ============================================================================
`default_nettype none

package weight_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG   = 3'd1,
    GRANT = 3'd2,
    WAITD = 3'd3,
    SEND  = 3'd4,
    COMP  = 3'd5,
    NEXT  = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam int unsigned LOG2_SIZE   = 4;
  localparam logic [15:0] TIMEOUT_MAX = 16'hFFFF;

  // One extra result bit keeps the rounding bias from overflowing.
  function automatic logic [64:0] ceil_tiles(input logic [63:0] x, input int unsigned lg);
    logic [64:0] bias;
    bias = (65'd1 << lg) - 65'd1;
    return ({1'b0, x} + bias) >> lg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sched_tile_counter.sv
// ============================================================================
// sched_tile_counter: tile index register with clear, increment, last flag
// Rev 1.0
// ============================================================================
`default_nettype none

module sched_tile_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] last_val,
  output logic [WIDTH-1:0] idx,
  output logic             is_last
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + WIDTH'(1);
    end
  end

  assign is_last = (idx == last_val);

endmodule

`default_nettype wire

// File: rtl/weight_tile_scheduler.sv
// ============================================================================
// weight_tile_scheduler: sequences weight-tile loads and IA tiles for one GEMM
// layer. Optional watchdog: define WEIGHT_SCHED_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module weight_tile_scheduler
  import weight_sched_pkg::*;
#(
  parameter int SIZE      = 1 << LOG2_SIZE,
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] k,
  input  logic [REG_WIDTH-1:0] n,
  input  logic [REG_WIDTH-1:0] m,
  output logic                 init_cfg,
  input  logic                 load_weight_req,
  output logic                 load_weight_granted,
  input  logic                 weight_data_valid,
  output logic                 send_weight_trigger,
  input  logic                 weight_sending_done,
  output logic                 ia_tile_start,
  input  logic                 ia_tile_done,
  output logic [REG_WIDTH-1:0] wt_tile_idx,
  output logic [REG_WIDTH-1:0] ia_tile_idx,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 err
);

  localparam int unsigned LG = $clog2(SIZE);

  state_t               state, state_next;
  logic [REG_WIDTH-1:0] k_lat, n_lat, m_lat;
  logic [REG_WIDTH-1:0] nmt_reg, wt_tiles_reg;
  logic [REG_WIDTH-1:0] nkt, nnt, nmt, wt_tiles;
  logic [REG_WIDTH-1:0] ia_last_val, wt_last_val;
  logic                 dims_zero, ia_last, wt_last;
  logic                 grant_next, send_next, ia_start_next;
  logic                 wt_clr, wt_inc, ia_clr, ia_inc, err_set;

  assign nkt       = REG_WIDTH'(ceil_tiles(64'(k_lat), LG));
  assign nnt       = REG_WIDTH'(ceil_tiles(64'(n_lat), LG));
  assign nmt       = REG_WIDTH'(ceil_tiles(64'(m_lat), LG));
  assign wt_tiles  = REG_WIDTH'(nkt * nnt);
  assign dims_zero = (k_lat == '0) || (n_lat == '0) || (m_lat == '0);

  assign ia_last_val = nmt_reg - REG_WIDTH'(1);
  assign wt_last_val = wt_tiles_reg - REG_WIDTH'(1);

  assign init_cfg   = (state == CFG);
  assign layer_done = (state == DONE);
  assign busy       = (state != IDLE);

`ifdef WEIGHT_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_run, wd_hold;

  assign wd_run = (state == WAITD) || (state == SEND) || (state == COMP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (wd_run && wd_hold) begin
      wd_cnt <= wd_cnt + 16'd1;
    end else begin
      wd_cnt <= '0;
    end
  end
`endif

  always_comb begin
    state_next    = state;
    grant_next    = 1'b0;
    send_next     = 1'b0;
    ia_start_next = 1'b0;
    wt_clr        = 1'b0;
    wt_inc        = 1'b0;
    ia_clr        = 1'b0;
    ia_inc        = 1'b0;
    err_set       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = CFG;
      CFG: begin
        wt_clr     = 1'b1;
        ia_clr     = 1'b1;
        state_next = dims_zero ? DONE : GRANT;
      end
      GRANT: if (load_weight_req) begin
        grant_next = 1'b1;
        state_next = WAITD;
      end
      WAITD: if (weight_data_valid) begin
        send_next  = 1'b1;
        state_next = SEND;
      end
      SEND: if (weight_sending_done) begin
        ia_clr        = 1'b1;
        ia_start_next = 1'b1;
        state_next    = COMP;
      end
      COMP: if (ia_tile_done) begin
        if (ia_last) begin
          state_next = NEXT;
        end else begin
          ia_inc        = 1'b1;
          ia_start_next = 1'b1;
        end
      end
      NEXT: if (wt_last) begin
        state_next = DONE;
      end else begin
        wt_inc     = 1'b1;
        ia_clr     = 1'b1;
        state_next = GRANT;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (ia_tile_done && (state != COMP)) err_set = 1'b1;
    if (weight_sending_done && (state != SEND)) err_set = 1'b1;

`ifdef WEIGHT_SCHED_TIMEOUT_EN
    // An IA handshake inside COMP restarts the count even though the state holds.
    wd_hold = (state_next == state) && !((state == COMP) && ia_tile_done);
    if (wd_run && wd_hold && (wd_cnt == TIMEOUT_MAX - 16'd1)) begin
      state_next = DONE;
      err_set    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      k_lat               <= '0;
      n_lat               <= '0;
      m_lat               <= '0;
      nmt_reg             <= '0;
      wt_tiles_reg        <= '0;
      load_weight_granted <= 1'b0;
      send_weight_trigger <= 1'b0;
      ia_tile_start       <= 1'b0;
      err                 <= 1'b0;
    end else begin
      state               <= state_next;
      load_weight_granted <= grant_next;
      send_weight_trigger <= send_next;
      ia_tile_start       <= ia_start_next;
      if (state == IDLE && start) begin
        k_lat <= k;
        n_lat <= n;
        m_lat <= m;
      end
      if (state == CFG) begin
        nmt_reg      <= nmt;
        wt_tiles_reg <= wt_tiles;
      end
      if (err_set) begin
        err <= 1'b1;
      end else if (state == IDLE && start) begin
        err <= 1'b0;
      end
    end
  end

  sched_tile_counter #(.WIDTH(REG_WIDTH)) u_wt_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wt_clr),
    .inc      (wt_inc),
    .last_val (wt_last_val),
    .idx      (wt_tile_idx),
    .is_last  (wt_last)
  );

  sched_tile_counter #(.WIDTH(REG_WIDTH)) u_ia_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ia_clr),
    .inc      (ia_inc),
    .last_val (ia_last_val),
    .idx      (ia_tile_idx),
    .is_last  (ia_last)
  );

endmodule

`default_nettype wire
